// File: rtl/manejo_matrices_turnos_pkg.sv
// Package shared by the board-routing stage of the battleship datapath.
// Contents: FSM state type, mode constants, empty-cell value and width
// helpers used to size player indices and board vectors.
package manejo_matrices_pkg;

  typedef enum logic {
    S_LISTO  = 1'b0,
    S_CONTEO = 1'b1
  } estado_t;

  localparam logic MODO_COLOCAR = 1'b1;
  localparam logic MODO_ATACAR  = 1'b0;

  // Cell value meaning "empty"; cast to CELL_W at the point of use.
  localparam int unsigned CELDA_VACIA = 0;

  // Index width that never collapses to zero bits (e.g. one player, 1x1 board).
  function automatic int unsigned ancho_min1(input int unsigned v);
    return (v < 2) ? 1 : $clog2(v);
  endfunction

  // Flat bit width of an n x n board of w-bit cells.
  function automatic int unsigned bits_tablero(input int unsigned n, input int unsigned w);
    return n * n * w;
  endfunction

endpackage

// File: rtl/manejo_matrices_turnos_if.sv
// Bus between the game controller (master) and the board-routing stage
// (slave).
//   master -> slave : colocar (mode request), cargar (load strobe),
//                     jugador (target player), matriz_posicion (snapshot)
//   slave -> master : listo, modo, rechazo, matriz_colocar, matriz_atacar,
//                     ocupadas
// Boards are packed [row][col][bit] so row-major cell i sits at bit i*CELL_W.
interface manejo_matrices_turnos_if #(
  parameter int N       = 5,
  parameter int CELL_W  = 2,
  parameter int NUM_JUG = 2
);
  import manejo_matrices_pkg::*;

  localparam int JUG_W = ancho_min1(NUM_JUG);
  localparam int CNT_W = $clog2(N * N + 1);

  logic                                         colocar;
  logic                                         cargar;
  logic [JUG_W-1:0]                             jugador;
  logic [N-1:0][N-1:0][CELL_W-1:0]              matriz_posicion;
  logic                                         listo;
  logic                                         modo;
  logic                                         rechazo;
  logic [NUM_JUG-1:0][N-1:0][N-1:0][CELL_W-1:0] matriz_colocar;
  logic [NUM_JUG-1:0][N-1:0][N-1:0][CELL_W-1:0] matriz_atacar;
  logic [NUM_JUG-1:0][CNT_W-1:0]                ocupadas;

  modport master (
    output colocar, cargar, jugador, matriz_posicion,
    input  listo, modo, rechazo, matriz_colocar, matriz_atacar, ocupadas
  );

  modport slave (
    input  colocar, cargar, jugador, matriz_posicion,
    output listo, modo, rechazo, matriz_colocar, matriz_atacar, ocupadas
  );

endinterface

// File: rtl/manejo_matrices_turnos_contador.sv
// contador_celdas: sequential nonzero-cell scanner.
// Visits one cell per clock in row-major order and counts cells != empty.
//   clk, rst : clock, synchronous active-high reset (aborts a scan)
//   start    : begin a scan on the next edge (ignored while busy)
//   tablero  : board to scan, must stay stable for the whole scan
//   done     : high during the last cell's cycle
//   cuenta   : final count, valid while done is high
// done/cuenta are combinational on the last cell so the consumer can
// register the result on that same edge.
module contador_celdas
  import manejo_matrices_pkg::*;
#(
  parameter  int N      = 5,
  parameter  int CELL_W = 2,
  localparam int CNT_W  = $clog2(N * N + 1),
  localparam int IDX_W  = ancho_min1(N * N)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start,
  input  logic [N-1:0][N-1:0][CELL_W-1:0] tablero,
  output logic                            done,
  output logic [CNT_W-1:0]                cuenta
);

  localparam int BITS = bits_tablero(N, CELL_W);

  logic              activo;
  logic [IDX_W-1:0]  idx;
  logic [CNT_W-1:0]  acc;
  logic [BITS-1:0]   plano;
  logic [CELL_W-1:0] celda;
  logic              ocupada;
  logic              ultimo;

  assign plano = tablero;

  always_comb begin
    celda = '0;
    for (int unsigned i = 0; i < N * N; i++) begin
      if (idx == IDX_W'(i)) celda = plano[i*CELL_W +: CELL_W];
    end
  end

  assign ocupada = (celda != CELL_W'(CELDA_VACIA));
  assign ultimo  = (idx == IDX_W'(N * N - 1));
  assign done    = activo && ultimo;
  assign cuenta  = acc + CNT_W'(ocupada);

  always_ff @(posedge clk) begin
    if (rst) begin
      activo <= 1'b0;
      idx    <= '0;
      acc    <= '0;
    end else if (activo) begin
      if (ultimo) begin
        activo <= 1'b0;
        idx    <= '0;
        acc    <= '0;
      end else begin
        idx <= idx + 1'b1;
        acc <= cuenta;
      end
    end else if (start) begin
      activo <= 1'b1;
      idx    <= '0;
      acc    <= '0;
    end
  end

endmodule

// File: rtl/manejo_matrices_turnos.sv
// manejo_matrices_turnos: per-player board routing stage.
// Holds placement ("colocar") and attack ("atacar") boards for NUM_JUG
// players, writes an incoming snapshot into the active-mode board of the
// selected player, clears the inactive-mode boards on a mode change and
// counts occupied cells of each placement board after every placement load.
//   clk, rst : clock, synchronous active-high reset
//   bus      : manejo_matrices_turnos_if.slave (requests in, boards/status out)
// Optional build macro MANEJO_MATRICES_BLOQUEO_EN: after the first 1->0 mode
// transition the mode is locked in attack until reset.
module manejo_matrices_turnos
  import manejo_matrices_pkg::*;
#(
  parameter int N       = 5,
  parameter int CELL_W  = 2,
  parameter int NUM_JUG = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  manejo_matrices_turnos_if.slave bus
);

  localparam int JUG_W = ancho_min1(NUM_JUG);
  localparam int CNT_W = $clog2(N * N + 1);

  estado_t                                      estado;
  logic                                         modo_r;
  logic                                         rechazo_r;
  logic [JUG_W-1:0]                             jug_lat;
  logic [NUM_JUG-1:0][N-1:0][N-1:0][CELL_W-1:0] col_r;
  logic [NUM_JUG-1:0][N-1:0][N-1:0][CELL_W-1:0] ata_r;
  logic [NUM_JUG-1:0][CNT_W-1:0]                ocu_r;

  logic                            en_listo;
  logic                            cambio;
  logic                            jug_valido;
  logic                            acepta;
  logic                            inicio;
  logic                            fin;
  logic [CNT_W-1:0]                cuenta;
  logic [N-1:0][N-1:0][CELL_W-1:0] tablero_lat;

  assign en_listo = (estado == S_LISTO);

`ifdef MANEJO_MATRICES_BLOQUEO_EN
  logic bloqueo;
  // A locked block treats colocar=1 as no request at all, so loads keep
  // flowing into the attack boards.
  assign cambio = en_listo && (bus.colocar != modo_r) && !(bloqueo && bus.colocar);
`else
  assign cambio = en_listo && (bus.colocar != modo_r);
`endif

  assign jug_valido = (int'(bus.jugador) < NUM_JUG);
  assign acepta     = en_listo && !cambio && bus.cargar && jug_valido;
  assign inicio     = acepta && (modo_r == MODO_COLOCAR);

  // The latched player's board cannot change during a scan: loads and mode
  // changes are both blocked outside S_LISTO.
  always_comb begin
    tablero_lat = '0;
    for (int unsigned j = 0; j < NUM_JUG; j++) begin
      if (jug_lat == JUG_W'(j)) tablero_lat = col_r[j];
    end
  end

  contador_celdas #(
    .N      (N),
    .CELL_W (CELL_W)
  ) u_contador (
    .clk     (clk),
    .rst     (rst),
    .start   (inicio),
    .tablero (tablero_lat),
    .done    (fin),
    .cuenta  (cuenta)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      estado    <= S_LISTO;
      modo_r    <= MODO_COLOCAR;
      rechazo_r <= 1'b0;
      jug_lat   <= '0;
      col_r     <= '0;
      ata_r     <= '0;
      ocu_r     <= '0;
`ifdef MANEJO_MATRICES_BLOQUEO_EN
      bloqueo   <= 1'b0;
`endif
    end else begin
      rechazo_r <= bus.cargar && !acepta;
      case (estado)
        S_LISTO: begin
          if (cambio) begin
            modo_r <= bus.colocar;
            if (bus.colocar == MODO_COLOCAR) begin
              ata_r <= '0;
            end else begin
              col_r <= '0;
              ocu_r <= '0;
`ifdef MANEJO_MATRICES_BLOQUEO_EN
              bloqueo <= 1'b1;
`endif
            end
          end else if (acepta) begin
            for (int unsigned j = 0; j < NUM_JUG; j++) begin
              if (bus.jugador == JUG_W'(j)) begin
                if (modo_r == MODO_COLOCAR) col_r[j] <= bus.matriz_posicion;
                else                        ata_r[j] <= bus.matriz_posicion;
              end
            end
            if (modo_r == MODO_COLOCAR) begin
              estado  <= S_CONTEO;
              jug_lat <= bus.jugador;
            end
          end
        end
        S_CONTEO: begin
          if (fin) begin
            for (int unsigned j = 0; j < NUM_JUG; j++) begin
              if (jug_lat == JUG_W'(j)) ocu_r[j] <= cuenta;
            end
            estado <= S_LISTO;
          end
        end
        default: estado <= S_LISTO;
      endcase
    end
  end

  assign bus.listo          = en_listo && !cambio;
  assign bus.modo           = modo_r;
  assign bus.rechazo        = rechazo_r;
  assign bus.matriz_colocar = col_r;
  assign bus.matriz_atacar  = ata_r;
  assign bus.ocupadas       = ocu_r;

endmodule
